// File: rtl/mmu_accumulator_if.sv
// Bus between the 3x3 systolic MMU / activation-stage reader and mmu_accumulator.
// The master drives the psum columns, control and read requests; the slave is
// the accumulator, which returns read data and status.
interface mmu_accumulator_if #(
   parameter int ACC_WIDTH = 32,
   parameter int ADDR_W    = 4
);
   logic                 valid_in;
   logic                 accumulate;
   logic                 use_signed;
   logic [ADDR_W-1:0]    wr_addr;
   logic [ACC_WIDTH-1:0] acc0_in;
   logic [ACC_WIDTH-1:0] acc1_in;
   logic [ACC_WIDTH-1:0] acc2_in;
   logic                 clear;
   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   logic                 rd_valid;
   logic [ACC_WIDTH-1:0] rd_data0;
   logic [ACC_WIDTH-1:0] rd_data1;
   logic [ACC_WIDTH-1:0] rd_data2;
   logic                 busy;
   logic                 overflow;

   modport master (
      output valid_in, accumulate, use_signed, wr_addr,
             acc0_in, acc1_in, acc2_in, clear, rd_en, rd_addr,
      input  rd_valid, rd_data0, rd_data1, rd_data2, busy, overflow
   );

   modport slave (
      input  valid_in, accumulate, use_signed, wr_addr,
             acc0_in, acc1_in, acc2_in, clear, rd_en, rd_addr,
      output rd_valid, rd_data0, rd_data1, rd_data2, busy, overflow
   );
endinterface

// File: rtl/mmu_accumulator.sv
// mmu_accumulator: re-aligns the column-skewed psum rows of the 3x3 MMU and
// overwrites/accumulates them into a DEPTH x 3 register buffer with a
// registered read port.
// Optional feature macro: ACC_SAT_EN -- accumulating adds that overflow
// saturate instead of wrapping (overflow flag is set either way).
module mmu_accumulator #(
   parameter int  ACC_WIDTH = 32,
   parameter int  DEPTH     = 16,
   localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input logic              clk,
   input logic              rst_n,
   mmu_accumulator_if.slave acc_if
);
   typedef logic [ACC_WIDTH-1:0]      word_t;
   typedef logic [2:0][ACC_WIDTH-1:0] row_t;

   // One extra bit so a non-power-of-two DEPTH can be range checked.
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   // Stage 1: row has seen its col0 edge; stage 2: row has seen its col1 edge.
   logic              s1_valid_q, s1_accum_q, s1_signed_q;
   logic [ADDR_W-1:0] s1_addr_q;
   word_t             s1_col0_q;
   logic              s2_valid_q, s2_accum_q, s2_signed_q;
   logic [ADDR_W-1:0] s2_addr_q;
   word_t             s2_col0_q, s2_col1_q;

   row_t              mem_q [DEPTH];
   logic              rd_valid_q;
   row_t              rd_data_q;
   logic              overflow_q;

   logic              wr_in_range, rd_in_range, commit_en;
   row_t              cur_row, in_row, new_row_d;
   logic [2:0]        col_ovf;

   assign wr_in_range = ({1'b0, s2_addr_q} < DEPTH_C);
   assign rd_in_range = ({1'b0, acc_if.rd_addr} < DEPTH_C);
   assign commit_en   = s2_valid_q && wr_in_range && !acc_if.clear;

   // The buffer is read combinationally at commit, so a row committing right
   // after another to the same entry always sees the previous result.
   assign cur_row = wr_in_range ? mem_q[s2_addr_q] : '0;
   assign in_row  = {acc_if.acc2_in, s2_col1_q, s2_col0_q};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_col
         logic [ACC_WIDTH:0] sum;
         logic               ovf_signed, ovf_unsigned;
         assign sum          = {1'b0, cur_row[gi]} + {1'b0, in_row[gi]};
         assign ovf_unsigned = sum[ACC_WIDTH];
         assign ovf_signed   = (cur_row[gi][ACC_WIDTH-1] == in_row[gi][ACC_WIDTH-1]) &&
                               (sum[ACC_WIDTH-1] != cur_row[gi][ACC_WIDTH-1]);
         // Overwrite can never overflow.
         assign col_ovf[gi]  = s2_accum_q && (s2_signed_q ? ovf_signed : ovf_unsigned);
`ifdef ACC_SAT_EN
         // Signed overflow needs equal operand signs, so the old value's sign
         // gives the saturation direction.
         word_t sat_val;
         assign sat_val = !s2_signed_q ? {ACC_WIDTH{1'b1}} :
                          (cur_row[gi][ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}});
         assign new_row_d[gi] = !s2_accum_q ? in_row[gi] :
                                (col_ovf[gi] ? sat_val : sum[ACC_WIDTH-1:0]);
`else
         assign new_row_d[gi] = s2_accum_q ? sum[ACC_WIDTH-1:0] : in_row[gi];
`endif
      end
   endgenerate

   // Deskew pipeline: capture col0 + control, then col1; clear flushes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_accum_q  <= 1'b0;
         s1_signed_q <= 1'b0;
         s1_addr_q   <= '0;
         s1_col0_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_accum_q  <= 1'b0;
         s2_signed_q <= 1'b0;
         s2_addr_q   <= '0;
         s2_col0_q   <= '0;
         s2_col1_q   <= '0;
      end else if (acc_if.clear) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= acc_if.valid_in;
         if (acc_if.valid_in) begin
            s1_accum_q  <= acc_if.accumulate;
            s1_signed_q <= acc_if.use_signed;
            s1_addr_q   <= acc_if.wr_addr;
            s1_col0_q   <= acc_if.acc0_in;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_accum_q  <= s1_accum_q;
            s2_signed_q <= s1_signed_q;
            s2_addr_q   <= s1_addr_q;
            s2_col0_q   <= s1_col0_q;
            s2_col1_q   <= acc_if.acc1_in;
         end
      end
   end

   // Result buffer: cleared as a whole, otherwise written by the commit stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (acc_if.clear) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit_en) begin
         mem_q[s2_addr_q] <= new_row_d;
      end
   end

   // Registered read port: sees the pre-commit / pre-clear contents, holds data when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= acc_if.rd_en;
         if (acc_if.rd_en) rd_data_q <= rd_in_range ? mem_q[acc_if.rd_addr] : '0;
      end
   end

   // Sticky overflow flag, reset only by clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               overflow_q <= 1'b0;
      else if (acc_if.clear)    overflow_q <= 1'b0;
      else if (commit_en && (|col_ovf)) overflow_q <= 1'b1;
   end

   // The incoming row counts as in flight from the cycle it is presented.
   assign acc_if.busy     = acc_if.valid_in || s1_valid_q || s2_valid_q;
   assign acc_if.overflow = overflow_q;
   assign acc_if.rd_valid = rd_valid_q;
   assign acc_if.rd_data0 = rd_data_q[0];
   assign acc_if.rd_data1 = rd_data_q[1];
   assign acc_if.rd_data2 = rd_data_q[2];
endmodule
